// File: rtl/output_tile_writer.sv
// Result write-back: requantizes each ARRAYWIDTH-lane output row to int8 and writes it to the result BRAM.
// Optional feature macro: OUTPUT_WRITER_SAT_EN (saturate requantized lanes instead of wrapping).
module output_tile_writer #(
    parameter int ARRAYWIDTH = 8,
    parameter int DATA_W     = 32,
    parameter int SHIFT      = 8,
    parameter int COL_TILES  = 25,
    parameter int ADDR_W     = 15,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   tile_row_idx,
    input  logic [4:0]                   tile_col_idx,
    input  logic                         out_valid,
    input  logic [DATA_W*ARRAYWIDTH-1:0] out_data,
    output logic                         wea,
    output logic [ADDR_W-1:0]            addra,
    output logic [8*ARRAYWIDTH-1:0]      dina,
    output logic                         busy,
    output logic                         done,
    output logic                         err_drop
);

    localparam int CNT_W = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;
    localparam logic signed [DATA_W-1:0] SAT_MAX = 127;
    localparam logic signed [DATA_W-1:0] SAT_MIN = -128;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_row_cnt;
    logic [2:0]               r_trow;
    logic [4:0]               r_tcol;
    logic [ADDR_W-1:0]        w_addr;
    logic [8*ARRAYWIDTH-1:0]  w_dina;

    function automatic logic [7:0] requant(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] s;
        s = x >>> SHIFT;
`ifdef OUTPUT_WRITER_SAT_EN
        if (s > SAT_MAX)      return 8'h7F;
        else if (s < SAT_MIN) return 8'h80;
        else                  return s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    // Address is formed at 32-bit precision, then wrapped into the BRAM address space.
    always_comb begin
        w_addr = ADDR_W'(BASE_ADDR + (int'(r_trow) * ARRAYWIDTH + int'(r_row_cnt)) * COL_TILES
                         + int'(r_tcol));
    end

    always_comb begin
        w_dina = '0;
        for (int i = 0; i < ARRAYWIDTH; i++) begin
            w_dina[8*i +: 8] = requant(out_data[DATA_W*i +: DATA_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_trow    <= '0;
            r_tcol    <= '0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        r_trow    <= tile_row_idx;
                        r_tcol    <= tile_col_idx;
                        r_row_cnt <= '0;
                        err_drop  <= out_valid;
                        r_state   <= S_CAPTURE;
                    end else if (out_valid) begin
                        err_drop <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (out_valid) begin
                        wea       <= 1'b1;
                        addra     <= w_addr;
                        dina      <= w_dina;
                        r_row_cnt <= r_row_cnt + CNT_W'(1);
                        if (r_row_cnt == CNT_W'(ARRAYWIDTH - 1)) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // busy stays high through the done pulse and drops on the following cycle.
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                    if (out_valid) err_drop <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_tile_writer.sv
// Randomized bench for output_tile_writer: two instances (base 0 and base 0x7FF0) share stimulus
// and are compared each cycle against an arithmetic reference model.
module tb_output_tile_writer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SH = 8;
    localparam int CT = 25;
    localparam int BASE1 = 32'h7FF0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2:0]     tile_row_idx = '0;
    logic [4:0]     tile_col_idx = '0;
    logic           out_valid = 1'b0;
    logic [DW*AW-1:0] out_data = '0;

    logic wea0, busy0, done0, err0, wea1, busy1, done1, err1;
    logic [14:0] addra0, addra1;
    logic [63:0] dina0, dina1;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int           m_phase = 0;
    int           m_rows = 0;
    int           m_tr = 0;
    int           m_tc = 0;
    bit           e_wea = 0, e_busy = 0, e_done = 0, e_err = 0;
    int           e_a0 = 0, e_a1 = 0;
    logic [63:0]  e_d = '0;

    output_tile_writer #(.ARRAYWIDTH(AW), .DATA_W(DW), .SHIFT(SH), .COL_TILES(CT),
                         .ADDR_W(15), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .tile_row_idx(tile_row_idx),
        .tile_col_idx(tile_col_idx), .out_valid(out_valid), .out_data(out_data),
        .wea(wea0), .addra(addra0), .dina(dina0), .busy(busy0), .done(done0), .err_drop(err0));

    output_tile_writer #(.ARRAYWIDTH(AW), .DATA_W(DW), .SHIFT(SH), .COL_TILES(CT),
                         .ADDR_W(15), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .tile_row_idx(tile_row_idx),
        .tile_col_idx(tile_col_idx), .out_valid(out_valid), .out_data(out_data),
        .wea(wea1), .addra(addra1), .dina(dina1), .busy(busy1), .done(done1), .err_drop(err1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_q(input logic [31:0] raw);
        longint v, d, q;
        v = longint'($signed(raw));
        d = longint'(1) << SH;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
`ifdef OUTPUT_WRITER_SAT_EN
        if (q > 127)  return 8'h7F;
        if (q < -128) return 8'h80;
`endif
        return 8'(q & 255);
    endfunction

    function automatic logic [63:0] ref_pack(input logic [DW*AW-1:0] d);
        logic [63:0] p;
        for (int i = 0; i < AW; i++) p[8*i +: 8] = ref_q(d[DW*i +: DW]);
        return p;
    endfunction

    function automatic int ref_addr(input int base, input int tr, input int tc, input int r);
        return (base + (tr * AW + r) * CT + tc) % 32768;
    endfunction

    function automatic logic [DW*AW-1:0] gen_row(input int mode, input int r);
        logic [DW*AW-1:0] d;
        logic [31:0] sat_vals [8];
        sat_vals = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'h0000_7F00,
                     32'hFFFF_8000, 32'h0000_ABCD, 32'h8000_0000, 32'h7FFF_FFFF};
        for (int i = 0; i < AW; i++) begin
            if (mode == 2) d[DW*i +: DW] = sat_vals[(i + r) % 8];
            else if ($urandom_range(1, 0) == 1) d[DW*i +: DW] = $urandom;
            else d[DW*i +: DW] = 32'($signed($urandom_range(80000, 0)) - 40000);
        end
        if (mode == 1) d[DW-1:0] = 32'h0000_0A00;
        return d;
    endfunction

    // One clock: drive inputs, advance the model at the edge, then compare just after it.
    task automatic step(input bit s, input int tr, input int tc, input bit v,
                        input logic [DW*AW-1:0] d);
        start = s; tile_row_idx = 3'(tr); tile_col_idx = 5'(tc);
        out_valid = v; out_data = d;
        @(posedge clk);
        e_wea = 0; e_done = 0;
        case (m_phase)
            0: begin
                e_busy = s;
                if (s) begin
                    m_tr = tr; m_tc = tc; m_rows = 0; e_err = v; m_phase = 1;
                end else if (v) e_err = 1;
            end
            1: if (v) begin
                e_wea = 1;
                e_a0 = ref_addr(0, m_tr, m_tc, m_rows);
                e_a1 = ref_addr(BASE1, m_tr, m_tc, m_rows);
                e_d = ref_pack(d);
                m_rows++;
                if (m_rows == AW) m_phase = 2;
            end
            default: begin
                e_done = 1; if (v) e_err = 1; m_phase = 0;
            end
        endcase
        #1;
        chk("wea0", 64'(wea0), 64'(e_wea));
        chk("wea1", 64'(wea1), 64'(e_wea));
        if (e_wea) begin
            chk("addra0", 64'(addra0), 64'(e_a0));
            chk("addra1", 64'(addra1), 64'(e_a1));
            chk("dina0", dina0, e_d);
            chk("dina1", dina1, e_d);
        end
        chk("busy", 64'(busy0), 64'(e_busy));
        chk("done", 64'(done0), 64'(e_done));
        chk("err_drop", 64'(err0), 64'(e_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; out_valid = 0;
        #1;
        chk("rst_wea", 64'(wea0), 64'd0);
        chk("rst_addra0", 64'(addra0), 64'd0);
        chk("rst_addra1", 64'(addra1), 64'd0);
        chk("rst_dina", dina0, 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        m_phase = 0; m_rows = 0; e_wea = 0; e_busy = 0; e_done = 0; e_err = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_tile(input int tr, input int tc, input int maxgap, input int mode);
        step(1, tr, tc, 0, '0);
        for (int r = 0; r < AW; r++) begin
            idle($urandom_range(maxgap, 0));
            step(0, 0, 0, 1, gen_row(mode, r));
        end
        idle(3);
    endtask

    initial begin
        #1;
        do_reset();
        idle(2);
        // nominal: row 1, col 3 -> addresses 203..378
        send_tile(1, 3, 0, 1);
        // saturation / wrap lane values
        send_tile(4, 17, 0, 2);
        // gapped burst
        send_tile(6, 24, 3, 0);
        // base-address wrap on the second instance
        send_tile(0, 0, 1, 0);
        // stray row in IDLE sets err_drop
        step(0, 0, 0, 1, gen_row(0, 0));
        idle(2);
        // start mid-burst, start with final row, start and row during DONE: all ignored
        step(1, 1, 2, 0, '0);
        for (int r = 0; r < 3; r++) step(0, 0, 0, 1, gen_row(0, r));
        step(1, 2, 9, 1, gen_row(0, 3));
        for (int r = 4; r < 7; r++) step(0, 0, 0, 1, gen_row(0, r));
        step(1, 5, 5, 1, gen_row(0, 7));
        step(1, 3, 3, 1, gen_row(0, 0));
        idle(2);
        // accepted start clears err_drop
        send_tile(3, 11, 0, 0);
        // reset after three writes, then a fresh tile from row 0
        step(1, 7, 30, 0, '0);
        for (int r = 0; r < 3; r++) step(0, 0, 0, 1, gen_row(0, r));
        do_reset();
        send_tile(7, 30, 0, 0);
        // randomized tiles with occasional stray rows
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(3, 0) == 0) step(0, 0, 0, 1, gen_row(0, 0));
            send_tile($urandom_range(7, 0), $urandom_range(31, 0), $urandom_range(3, 0),
                      $urandom_range(2, 0));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/output_tile_writer.md
# output_tile_writer

Write-back engine at the far end of the conv datapath. Accepts the ARRAYWIDTH-row burst from the accelerator output buffer, one row per `out_valid` cycle. Requantizes each DATA_W-bit signed lane to int8 and writes each packed row into the result BRAM. Write addresses come from the tile row/column indices issued by ConvController, the mirror of the read-side address generators that feed the input and weight BRAMs.

## Interface
Parameters:
- ARRAYWIDTH, 8, lanes per row and rows per tile
- DATA_W, 32, output-buffer lane width (signed)
- SHIFT, 8, requant arithmetic right shift, 0..DATA_W-1
- COL_TILES, 25, tile columns per output row-stripe
- ADDR_W, 15, result BRAM address width
- BASE_ADDR, 0, result region base word address

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches tile indices, arms the writer
- tile_row_idx  in  3  tile row of the burst
- tile_col_idx  in  5  tile column of the burst
- out_valid  in  1  out_data holds one valid row (from output_buffer_out_en)
- out_data  in  DATA_W*ARRAYWIDTH  row; lane i = bits [DATA_W*(i+1)-1 : DATA_W*i]
- wea  out  1  BRAM write enable
- addra  out  ADDR_W  BRAM write address
- dina  out  8*ARRAYWIDTH  packed int8 row; lane i = bits [8*i+7 : 8*i]
- busy  out  1  high in CAPTURE and DONE
- done  out  1  one-cycle pulse after the last row write
- err_drop  out  1  sticky; a row arrived while IDLE

## Operation
- FSM states:
  - IDLE: `start` latches the tile indices, clears row_cnt and err_drop, and moves to CAPTURE.
  - CAPTURE: each `out_valid` cycle registers one row write and increments row_cnt. The row with row_cnt == ARRAYWIDTH-1 moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- `start` outside IDLE is ignored. This includes `start` in the same cycle as the final row and `start` during DONE.
- `out_valid` in IDLE or DONE: the row is dropped, no write, err_drop set. err_drop clears only on an accepted `start` or on reset.
- Gaps in `out_valid` during CAPTURE are allowed; row_cnt holds.
- Write address for row r: BASE_ADDR + ((tile_row_idx*ARRAYWIDTH + r)*COL_TILES + tile_col_idx). Computed at full precision, then truncated modulo 2^ADDR_W (wraps silently).
- Requant per lane: arithmetic shift right by SHIFT (floor toward -inf), then narrowed to 8 bits per Configuration.

## Timing
- Reset values: wea=0, addra=0, dina=0, busy=0, done=0, err_drop=0, FSM=IDLE, row_cnt=0.
- Latency: a row accepted at edge N drives wea/addra/dina registered from edge N, valid for exactly one cycle. Back-to-back rows give one write per cycle.
- busy rises the cycle after `start` is sampled.
- done rises one cycle after the final write's wea and coincides with busy still high. busy falls the next cycle.
- Asserting rst mid-burst forces all outputs to their reset values immediately. The partial tile is abandoned; the next `start` begins at row 0.
- No backpressure: the BRAM port always accepts writes.

## Configuration
- OUTPUT_WRITER_SAT_EN defined: each shifted lane saturates to [-128, 127].
- OUTPUT_WRITER_SAT_EN undefined: each shifted lane keeps its low 8 bits (wrap), with no saturation logic.

## Test plan
Defaults apply unless noted.
- Nominal: start with row=1, col=3, then 8 consecutive rows, lane0=0x00000A00. Expect wea on 8 consecutive cycles, addra=203,228,253,…,378, dina[7:0]=0x0A, and done one cycle after the last write.
- Saturation: lane values 0x00010000, 0xFFFF0000, 0xFFFFFF00. With SAT_EN expect 0x7F, 0x80, 0xFF. Without SAT_EN expect 0x00, 0x00, 0xFF.
- Gapped burst: rows sent with 1–3 idle cycles between them. Expect the same 8 addresses in order, row_cnt holding across gaps, and done after row 7 only.
- Drop/ignore:
  - `out_valid` pulse in IDLE: expect no wea and err_drop=1.
  - `start` with row=2 issued mid-burst: expect it ignored, with addresses continuing for the original tile.
  - next accepted `start`: expect err_drop cleared.
- Reset mid-op: assert rst after 3 writes. Expect wea=0, busy=0, addra=0 immediately. A new start then writes from row 0.
- Wrap: BASE_ADDR=0x7FF0, row=0, col=0, COL_TILES=25. Expect addra=0x7FF0, 0x0009, 0x0022, … (mod 2^15).
